// File: rtl/transmisor_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package transmisor_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CLK_DIV = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } estado_e;

    // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
    function automatic logic paridad_par(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/contador_baudios.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module contador_baudios
    import transmisor_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CLK_DIV - 1);

    logic [CW-1:0] cuenta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= '0;
        end else if (clear || (cuenta_q == ULTIMO)) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_q + CW'(1);
        end
    end

    assign bit_end = !clear && (cuenta_q == ULTIMO);

endmodule

// File: rtl/transmisor_serial.sv
// Parallel-in, serial-out transmitter: start bit, data LSB first, optional even parity, stop bit.
module transmisor_serial
    import transmisor_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] ULTIMO_BIT = IW'(DATA_W - 1);

    estado_e           estado_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_sig;
    logic [IW-1:0]     indice_q;
    logic              paridad_q;
    logic              bit_end;
    logic              limpiar;

    assign shift_sig = shift_q >> 1;
    // Holding the divider clear while idle makes the first START cycle count 0.
    assign limpiar   = (estado_q == StIdle);

    contador_baudios #(
        .CLK_DIV(CLK_DIV)
    ) u_contador (
        .clk    (clk),
        .reset  (reset),
        .clear  (limpiar),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= StIdle;
            shift_q   <= '0;
            indice_q  <= '0;
            paridad_q <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado_q)
                StIdle: begin
                    if (start) begin
                        shift_q   <= din;
                        paridad_q <= paridad_par(16'(din));
                        estado_q  <= StStart;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        estado_q <= StData;
                        indice_q <= '0;
                        tx       <= shift_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q  <= shift_sig;
                        indice_q <= indice_q + IW'(1);
                        if (indice_q == ULTIMO_BIT) begin
                            if (PARITY_EN) begin
                                estado_q <= StParity;
                                tx       <= paridad_q;
                            end else begin
                                estado_q <= StStop;
                                tx       <= 1'b1;
                            end
                        end else begin
                            tx <= shift_sig[0];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        estado_q <= StStop;
                        tx       <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        estado_q <= StIdle;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    estado_q <= StIdle;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmisor_serial.sv
// Scoreboard bench: stimulus queues expected line patterns, monitors check each frame on the wire.
module tb_transmisor_serial;

    localparam int unsigned CD = 4;

    typedef struct {
        logic [15:0] bits;   // time order, first bit at position nbits-1
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst0, rst1, start0, start1;
    logic [7:0] din0, din1;
    logic       tx0, busy0, done0, tx1, busy1, done1;

    int total   = 0;
    int bad     = 0;
    int frames0 = 0;
    int frames1 = 0;

    frame_t q0[$];
    frame_t q1[$];

    always #5 clk = ~clk;

    transmisor_serial #(
        .DATA_W   (8),
        .CLK_DIV  (CD),
        .PARITY_EN(1'b1)
    ) u_dut0 (
        .clk  (clk),
        .reset(rst0),
        .start(start0),
        .din  (din0),
        .tx   (tx0),
        .busy (busy0),
        .done (done0)
    );

    transmisor_serial #(
        .DATA_W   (8),
        .CLK_DIV  (CD),
        .PARITY_EN(1'b0)
    ) u_dut1 (
        .clk  (clk),
        .reset(rst1),
        .start(start1),
        .din  (din1),
        .tx   (tx1),
        .busy (busy1),
        .done (done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done0 : done1;
    endfunction

    function automatic logic rst_of(input int w);
        return (w == 0) ? rst0 : rst1;
    endfunction

    task automatic push(input int w, input logic [15:0] b, input int n);
        frame_t f;
        f.bits  = b;
        f.nbits = n;
        if (w == 0) q0.push_back(f);
        else        q1.push_back(f);
    endtask

    // One-cycle start pulse; on return the accept edge has just passed.
    task automatic send(input int w, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (w == 0) begin start0 = 1'b1; din0 = d; end
        else        begin start1 = 1'b1; din1 = d; end
        @(posedge clk);
        #1;
        if (w == 0) start0 = 1'b0;
        else        start1 = 1'b0;
        chk("busy_after_accept", busy_of(w), 1'b1);
        chk("tx_low_after_accept", tx_of(w), 1'b0);
    endtask

    task automatic wait_frames(input int w, input int n);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (((w == 0) ? frames0 : frames1) >= n) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
        end
        chk("frame_completion_in_time", reached, 1'b1);
        @(posedge clk);
    endtask

    task automatic monitor(input int w);
        frame_t f;
        logic   abort;
        logic   have;
        forever begin
            @(negedge clk);
            chk("done_low_outside_end", done_of(w), 1'b0);
            if (busy_of(w) && !rst_of(w)) begin
                have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
                chk("frame_was_expected", have, 1'b1);
                if (have) begin
                    f     = (w == 0) ? q0.pop_front() : q1.pop_front();
                    abort = 1'b0;
                    for (int k = 0; k < f.nbits * CD; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_of(w)) begin
                            abort = 1'b1;
                            break;
                        end
                        chk("busy_in_frame", busy_of(w), 1'b1);
                        chk("tx_bit", tx_of(w), f.bits[f.nbits - 1 - k / CD]);
                    end
                    if (!abort) begin
                        @(negedge clk);
                        if (!rst_of(w)) begin
                            chk("busy_low_done_cycle", busy_of(w), 1'b0);
                            chk("done_pulse", done_of(w), 1'b1);
                            chk("tx_idle_done_cycle", tx_of(w), 1'b1);
                            if (w == 0) frames0++;
                            else        frames1++;
                        end
                    end
                end
            end else begin
                chk("tx_idle_high", tx_of(w), 1'b1);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        logic seen_done;
        logic accepted;

        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        #3;
        chk("reset_tx0", tx0, 1'b1);
        chk("reset_busy0", busy0, 1'b0);
        chk("reset_done0", done0, 1'b0);
        chk("reset_tx1", tx1, 1'b1);
        chk("reset_busy1", busy1, 1'b0);
        chk("reset_done1", done1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // 8'hA5 with parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
        push(0, 11'b0_10100101_0_1, 11);
        send(0, 8'hA5);
        wait_frames(0, 1);

        // 8'h07: data 1,1,1,0,0,0,0,0, parity 1
        push(0, 11'b0_11100000_1_1, 11);
        send(0, 8'h07);
        wait_frames(0, 2);

        // No parity slot: stop follows bit 7
        push(1, 10'b0_11111111_1, 10);
        send(1, 8'hFF);
        wait_frames(1, 1);

        // Mid-frame request ignored; request held across done cycle starts 8'h3C at once
        push(0, 11'b0_10100101_0_1, 11);
        push(0, 11'b0_00111100_0_1, 11);
        send(0, 8'hA5);
        repeat (10) @(posedge clk);
        #1;
        start0 = 1'b1;
        din0   = 8'h00;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        din0   = 8'hFF;
        repeat (20) @(posedge clk);
        #1;
        start0   = 1'b1;
        din0     = 8'h3C;
        accepted = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                @(posedge clk);
                #1;
                start0   = 1'b0;
                accepted = 1'b1;
                chk("b2b_tx_low", tx0, 1'b0);
                chk("b2b_busy_high", busy0, 1'b1);
                break;
            end
        end
        start0 = 1'b0;
        chk("b2b_done_seen", accepted, 1'b1);
        wait_frames(0, 4);

        // Async reset during data bit 3 (a 0 bit of 8'hA5)
        push(0, 11'b0_10100101_0_1, 11);
        send(0, 8'hA5);
        repeat (16) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy0, 1'b1);
        chk("pre_reset_tx_bit3", tx0, 1'b0);
        #1;
        rst0 = 1'b1;
        #1;
        chk("async_reset_tx", tx0, 1'b1);
        chk("async_reset_busy", busy0, 1'b0);
        chk("async_reset_done", done0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst0      = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done0;
        end
        chk("no_done_after_abort", seen_done, 1'b0);

        // 8'h5A after reset: data 0,1,0,1,1,0,1,0, parity 0
        push(0, 11'b0_01011010_0_1, 11);
        send(0, 8'h5A);
        wait_frames(0, 5);

        // din scrambled every cycle after accept; 8'hC3 must go out
        push(0, 11'b0_11000011_0_1, 11);
        send(0, 8'hC3);
        for (int i = 0; i < 46; i++) begin
            @(posedge clk);
            #1;
            din0 = 8'($urandom);
        end
        wait_frames(0, 6);

        repeat (4) @(posedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        chk("frames0_count", frames0, 6);
        chk("frames1_count", frames1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transmisor_serial.md
Name: transmisor_serial

Overview:
- Parallel-in, serial-out transmitter for a byte-wide enabled holding register.
- Accepts a DATA_W-bit word plus a start strobe, then serialises it as a framed bit stream on a single line.
- Frame: start bit, data LSB first, optional even parity, stop bit.
- Sits on the sending end of the board's serial link. The far-end receiver/deserialiser recovers the bits and writes them into a byte register under its enable.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLK_DIV, 16, clk cycles per serial bit (>=2)
PARITY_EN, 1, 1 = insert even-parity bit after data, 0 = no parity bit

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset; forces idle immediately
start  input  1  request to send; sampled on rising clk
din  input  DATA_W  word to send; captured on the accepted start edge only
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, active-high) values:
  - tx=1, busy=0, done=0.
  - State IDLE; baud counter=0; bit index=0; shift register=0.
  - Reset asserted mid-frame aborts the frame at once: tx returns high without waiting for the clock, and no done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - If start=1 on a rising edge: latch din into the shift register, clear the baud counter, compute even parity (XOR of din), go to START.
  - din is ignored at all other times.
- Bit timing:
  - Each of START/DATA/PARITY/STOP holds tx for exactly CLK_DIV cycles.
  - The baud counter runs 0..CLK_DIV-1; the bit ends on the cycle where counter==CLK_DIV-1. The counter then wraps to 0.
- START: tx=0. At bit end, go to DATA with bit index=0.
- DATA:
  - tx=shift[0].
  - At bit end: shift right by one and increment the bit index.
  - After bit index DATA_W-1, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx=stored parity bit. At bit end, go to STOP.
- STOP: tx=1. At bit end, go to IDLE and assert done for exactly that one following cycle (the first IDLE cycle).
- busy:
  - Registered; goes high in the cycle after the accepted start edge, i.e. the same cycle tx first goes low.
  - Stays high through the final STOP cycle.
  - Low in the done cycle.
- Latency: tx falls 1 cycle after the start edge. Frame length is (2 + DATA_W + PARITY_EN) * CLK_DIV cycles.
- start while busy=1 is ignored, not queued.
- start asserted in the done cycle is accepted; back-to-back frames have no extra idle gap.
- tx, busy and done are all registered outputs (glitch-free).
- No tx change except on a bit boundary or an async reset.

Decomposition:
- Shared package transmisor_pkg:
  - state encoding constants (IDLE..STOP, 3 bits);
  - a parity function (XOR reduce);
  - the default CLK_DIV and DATA_W constants.
- One sub-module is natural: contador_baudios, the parameterised CLK_DIV divider.
  - Inputs: clk, reset, clear.
  - Output: a one-cycle bit_end tick.
  - Instantiated once.
- Remaining FSM, shift register and output logic live in transmisor_serial.

Test Plan:
1. CLK_DIV=4, PARITY_EN=1, start pulse with din=8'hA5 -> line bits, each 4 cycles:
   - 0 (start), 1,0,1,0,0,1,0,1 (data), 0 (parity), 1 (stop);
   - busy high 44 cycles; done one pulse at cycle 45.
2. Same config, din=8'h07 -> data bits 1,1,1,0,0,0,0,0; parity bit 1; busy duration 44 cycles.
3. PARITY_EN=0, CLK_DIV=4, din=8'hFF -> busy 40 cycles; no parity slot (stop follows bit 7 directly).
4. start re-pulsed with din=8'h00 mid-frame, then held high across the done cycle with din=8'h3C:
   - mid-frame request ignored; first frame still carries 8'hA5;
   - second frame (8'h3C) starts immediately, tx low in the cycle after done.
5. reset asserted asynchronously (between clock edges) during DATA bit 3 -> tx=1, busy=0 before the next edge; no done pulse.
   - After reset release, a new start with 8'h5A transmits a complete, correct frame.
6. din changed every cycle during a frame -> transmitted bits equal the value latched at the accept edge only.
